// File: rtl/dmem_pkg.sv
// Shared types and sizes for the two-port data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DMEM_WORDS = 512;
    localparam int unsigned DMEM_DW    = 32;
    localparam int unsigned DMEM_CW    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_arb_state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational winner selection between the two requesters.
// Tie rule: round-robin when DMEM_ARB_RR_EN is defined, else port 0 wins.
module dmem_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic win_o_c
);

    logic tie_win;

`ifdef DMEM_ARB_RR_EN
    assign tie_win = ~last_gnt_i;
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt_i;
    assign tie_win         = 1'b0;
`endif

    always_comb begin
        win_o_c = 1'b0;
        if (req0_i && req1_i) begin
            win_o_c = tie_win;
        end else if (req1_i) begin
            win_o_c = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the shared 512-word data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking (default: port 0 priority).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [AW-1:0]      adr0,
    input  logic [AW-1:0]      adr1,
    input  logic [DMEM_DW-1:0] wdata0,
    input  logic [DMEM_DW-1:0] wdata1,
    output logic               done0,
    output logic               done1,
    output logic [DMEM_DW-1:0] rdata,
    output logic [AW-1:0]      mem_adr,
    output logic [DMEM_DW-1:0] mem_wdata,
    output logic               mem_MR,
    output logic               mem_MW,
    input  logic [DMEM_DW-1:0] mem_rdata,
    output logic               busy,
    output logic               gnt_id
);

    localparam logic [AW-1:0] ADR_MASK = ~AW'(3);

    dmem_arb_state_t    state_q, state_d;
    logic [DMEM_CW-1:0] cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [DMEM_DW-1:0] wdata_q, wdata_d;
    logic [DMEM_DW-1:0] rdata_q, rdata_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic               mr_q, mr_d;
    logic               mw_q, mw_d;
    logic               busy_q, busy_d;
    logic               gnt_q, gnt_d;
    logic               last_q, last_d;

    logic               pick_c;
    logic               sel_we_c;
    logic [AW-1:0]      sel_adr_c;
    logic [DMEM_DW-1:0] sel_wdata_c;

    dmem_rr_pick u_pick (
        .req0_i     (req0),
        .req1_i     (req1),
        .last_gnt_i (last_q),
        .win_o_c    (pick_c)
    );

    assign sel_we_c    = pick_c ? we1    : we0;
    assign sel_adr_c   = pick_c ? adr1   : adr0;
    assign sel_wdata_c = pick_c ? wdata1 : wdata0;

    // Sequencer: grant in IDLE, hold controls through ACCESS, pulse done in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        mr_d    = mr_q;
        mw_d    = mw_q;
        busy_d  = busy_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    gnt_d   = pick_c;
                    last_d  = pick_c;
                    we_d    = sel_we_c;
                    adr_d   = sel_adr_c & ADR_MASK;
                    wdata_d = sel_wdata_c;
                    cnt_d   = DMEM_CW'(MEM_LAT - 1);
                    mr_d    = ~sel_we_c;
                    mw_d    = sel_we_c;
                    busy_d  = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                    mr_d    = 1'b0;
                    mw_d    = 1'b0;
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                end else begin
                    cnt_d = cnt_q - DMEM_CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                mr_d    = 1'b0;
                mw_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // last_q resets to 1 so the first round-robin tie after reset goes to port 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            busy_q  <= busy_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign mem_MR    = mr_q;
    assign mem_MW    = mw_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance 0 with MEM_LAT=1, instance 1 with MEM_LAT=3.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req0_s, req1_s, we0_s, we1_s;
    logic [1:0][31:0] adr0_s, adr1_s, wdata0_s, wdata1_s;
    logic [1:0]       done0_s, done1_s, mr_s, mw_s, busy_s, gnt_s;
    logic [1:0][31:0] rdata_s, mem_adr_s, mem_wdata_s, mem_rdata_s;

    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];
    logic [1:0]  pre_we;
    logic [8:0]  pre_a;
    logic [31:0] pre_d;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.MEM_LAT(1), .AW(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req0_s[0]), .req1(req1_s[0]), .we0(we0_s[0]), .we1(we1_s[0]),
        .adr0(adr0_s[0]), .adr1(adr1_s[0]), .wdata0(wdata0_s[0]), .wdata1(wdata1_s[0]),
        .done0(done0_s[0]), .done1(done1_s[0]), .rdata(rdata_s[0]),
        .mem_adr(mem_adr_s[0]), .mem_wdata(mem_wdata_s[0]),
        .mem_MR(mr_s[0]), .mem_MW(mw_s[0]), .mem_rdata(mem_rdata_s[0]),
        .busy(busy_s[0]), .gnt_id(gnt_s[0])
    );

    dmem_arbiter #(.MEM_LAT(3), .AW(32)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0(req0_s[1]), .req1(req1_s[1]), .we0(we0_s[1]), .we1(we1_s[1]),
        .adr0(adr0_s[1]), .adr1(adr1_s[1]), .wdata0(wdata0_s[1]), .wdata1(wdata1_s[1]),
        .done0(done0_s[1]), .done1(done1_s[1]), .rdata(rdata_s[1]),
        .mem_adr(mem_adr_s[1]), .mem_wdata(mem_wdata_s[1]),
        .mem_MR(mr_s[1]), .mem_MW(mw_s[1]), .mem_rdata(mem_rdata_s[1]),
        .busy(busy_s[1]), .gnt_id(gnt_s[1])
    );

    always_comb begin
        mem_rdata_s[0] = mem0[mem_adr_s[0][10:2]];
        mem_rdata_s[1] = mem1[mem_adr_s[1][10:2]];
    end

    always @(posedge clk) begin
        if (pre_we[0]) mem0[pre_a] <= pre_d;
        else if (mw_s[0]) mem0[mem_adr_s[0][10:2]] <= mem_wdata_s[0];
        if (pre_we[1]) mem1[pre_a] <= pre_d;
        else if (mw_s[1]) mem1[mem_adr_s[1][10:2]] <= mem_wdata_s[1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int k, input logic [8:0] a, input logic [31:0] d);
        pre_we    = '0;
        pre_we[k] = 1'b1;
        pre_a     = a;
        pre_d     = d;
        tick();
        pre_we = '0;
    endtask

    // One request on instance k, port p; observes the ACCESS window and the done cycle.
    task automatic acc(input int k, input bit p, input bit w, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output int nmr, output int nmw,
                       output logic [31:0] a_seen, output logic [31:0] rd, output bit stable);
        bit got = 1'b0;
        bit first = 1'b1;
        logic [31:0] a0 = '0;
        logic [31:0] d0 = '0;
        logic mw0 = 1'b0;
        lat = 0; nmr = 0; nmw = 0; a_seen = '0; rd = '0; stable = 1'b1;
        if (p) begin
            req1_s[k] = 1'b1; we1_s[k] = w; adr1_s[k] = a; wdata1_s[k] = d;
        end else begin
            req0_s[k] = 1'b1; we0_s[k] = w; adr0_s[k] = a; wdata0_s[k] = d;
        end
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (mr_s[k] || mw_s[k]) begin
                if (first) begin
                    a0 = mem_adr_s[k]; d0 = mem_wdata_s[k]; mw0 = mw_s[k];
                    a_seen = a0; first = 1'b0;
                end else if (mem_adr_s[k] !== a0 || mem_wdata_s[k] !== d0 || mw_s[k] !== mw0) begin
                    stable = 1'b0;
                end
                if (mr_s[k] && mw_s[k]) stable = 1'b0;
                nmr += int'(mr_s[k]);
                nmw += int'(mw_s[k]);
            end
            if ((p ? done1_s[k] : done0_s[k]) === 1'b1) begin
                got = 1'b1;
                lat = i;
                rd  = rdata_s[k];
            end
        end
        req0_s[k] = 1'b0;
        req1_s[k] = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        tick();
        check("idle_after", 32'(busy_s[k]), 32'd0);
    endtask

    int          lat, nmr, nmw, n0, n1, nd;
    logic [31:0] a_seen, rd;
    bit          stable;
    logic [3:0]  seq, seq_exp;

    initial begin
        rst = 1'b1;
        req0_s = '0; req1_s = '0; we0_s = '0; we1_s = '0;
        adr0_s = '0; adr1_s = '0; wdata0_s = '0; wdata1_s = '0;
        pre_we = '0; pre_a = '0; pre_d = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("rst_done0", 32'(done0_s[0]), 32'd0);
        check("rst_done1", 32'(done1_s[0]), 32'd0);
        check("rst_mr", 32'(mr_s[0]), 32'd0);
        check("rst_mw", 32'(mw_s[0]), 32'd0);
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_gnt", 32'(gnt_s[0]), 32'd0);
        check("rst_adr", mem_adr_s[0], 32'd0);
        check("rst_wdata", mem_wdata_s[0], 32'd0);
        check("rst_rdata", rdata_s[0], 32'd0);

        // Single read, MEM_LAT=1
        preload(0, 9'd4, 32'hDEAD_BEEF);
        acc(0, 1'b0, 1'b0, 32'h10, 32'h0, lat, nmr, nmw, a_seen, rd, stable);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_mr_cycles", 32'(nmr), 32'd1);
        check("rd_mw_cycles", 32'(nmw), 32'd0);
        check("rd_adr", a_seen, 32'h10);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_gnt", 32'(gnt_s[0]), 32'd0);

        // Port 1 write then read-back
        acc(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, lat, nmr, nmw, a_seen, rd, stable);
        check("wr_mw_cycles", 32'(nmw), 32'd1);
        check("wr_mr_cycles", 32'(nmr), 32'd0);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_rdata_held", rd, 32'hDEAD_BEEF);
        check("wr_gnt", 32'(gnt_s[0]), 32'd1);
        acc(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, nmr, nmw, a_seen, rd, stable);
        check("rb_data", rd, 32'h1234_5678);

        // Simultaneous requests from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_s[0] = 1'b1; we0_s[0] = 1'b0; adr0_s[0] = 32'h10;
        req1_s[0] = 1'b1; we1_s[0] = 1'b0; adr1_s[0] = 32'h20;
        n0 = 0; n1 = 0; nd = 0; seq = '0;
        for (int i = 0; i < 60 && nd < 4; i++) begin
            tick();
            if (done0_s[0]) begin n0++; nd++; seq = {seq[2:0], 1'b0}; end
            if (done1_s[0]) begin n1++; nd++; seq = {seq[2:0], 1'b1}; end
        end
        req0_s[0] = 1'b0;
        req1_s[0] = 1'b0;
        tick();
        tick();
`ifdef DMEM_ARB_RR_EN
        seq_exp = 4'b0101;
        check("tie_n0", 32'(n0), 32'd2);
        check("tie_n1", 32'(n1), 32'd2);
`else
        seq_exp = 4'b0000;
        check("tie_n0", 32'(n0), 32'd4);
        check("tie_n1", 32'(n1), 32'd0);
`endif
        check("tie_order", 32'(seq), 32'(seq_exp));
        check("tie_idle", 32'(busy_s[0]), 32'd0);

        // MEM_LAT=3, misaligned address
        preload(1, 9'd4, 32'hCAFE_F00D);
        acc(1, 1'b0, 1'b0, 32'h13, 32'h0, lat, nmr, nmw, a_seen, rd, stable);
        check("l3_lat", 32'(lat), 32'd4);
        check("l3_mr_cycles", 32'(nmr), 32'd3);
        check("l3_adr", a_seen, 32'h10);
        check("l3_stable", 32'(stable), 32'd1);
        check("l3_data", rd, 32'hCAFE_F00D);

        // Write with MEM_LAT=3: stable controls for 3 cycles
        acc(1, 1'b1, 1'b1, 32'h81, 32'hA5A5_0001, lat, nmr, nmw, a_seen, rd, stable);
        check("l3w_mw_cycles", 32'(nmw), 32'd3);
        check("l3w_adr", a_seen, 32'h80);
        check("l3w_stable", 32'(stable), 32'd1);
        check("l3w_rdata_held", rd, 32'hCAFE_F00D);

        // Reset in the 2nd ACCESS cycle of a write
        req0_s[1] = 1'b1; we0_s[1] = 1'b1; adr0_s[1] = 32'h40; wdata0_s[1] = 32'h55;
        tick();
        tick();
        check("mid_mw_before", 32'(mw_s[1]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_mw_async", 32'(mw_s[1]), 32'd0);
        check("mid_mr_async", 32'(mr_s[1]), 32'd0);
        check("mid_busy", 32'(busy_s[1]), 32'd0);
        req0_s[1] = 1'b0;
        tick();
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nd += int'(done0_s[1]) + int'(done1_s[1]);
        end
        check("mid_no_done", 32'(nd), 32'd0);
        acc(1, 1'b0, 1'b0, 32'h10, 32'h0, lat, nmr, nmw, a_seen, rd, stable);
        check("post_rst_lat", 32'(lat), 32'd4);
        check("post_rst_data", rd, 32'hCAFE_F00D);

        // Early req drop: access still completes with one done
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; adr0_s[1] = 32'h10;
        tick();
        req0_s[1] = 1'b0;
        n0 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n0 += int'(done0_s[1]);
        end
        check("drop_done_once", 32'(n0), 32'd1);
        check("drop_idle", 32'(busy_s[1]), 32'd0);
        check("drop_mr_low", 32'(mr_s[1]), 32'd0);
        check("drop_rdata", rdata_s[1], 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the shared 32-bit data memory (512 words, word-addressed via `adr[31:2]`). It sits between two requesters (port 0: CPU load/store path; port 1: DMA/debug loader) and the memory's `adr`/`writedata`/`MR`/`MW`/`readdata` pins. It serialises accesses, holds memory controls stable for a fixed latency window, and returns read data with a one-cycle done pulse.

## Interface
- `MEM_LAT`, default 1: cycles the memory controls are held per access (range 1–7).
- `AW`, default 32: address width.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `req0` / `req1  in  1`: access request; held high until the matching `done`.
- `we0` / `we1  in  1`: 1 = write, 0 = read; sampled at grant.
- `adr0` / `adr1  in  AW`: byte address; sampled at grant.
- `wdata0` / `wdata1  in  32`: write data; sampled at grant.
- `done0` / `done1  out  1`: one-cycle completion pulse.
- `rdata  out  32`: read data; valid in the `done` cycle, held until the next read completes.
- `mem_adr  out  AW`: to memory `adr`; bits [1:0] forced to 0.
- `mem_wdata  out  32`: to memory `writedata`.
- `mem_MR` / `mem_MW  out  1`: to memory `MR` / `MW`.
- `mem_rdata  in  32`: from memory `readdata`.
- `busy  out  1`: high in ACCESS and RESP.
- `gnt_id  out  1`: port currently or last granted.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any `req` is high, pick a winner, latch its `we`/`adr`/`wdata` into internal registers, load the latency counter with `MEM_LAT-1`, set `gnt_id`, and go to ACCESS. With no request, stay in IDLE.
- ACCESS: `mem_adr`/`mem_wdata` are driven from the latched registers. Exactly one of `mem_MR`/`mem_MW` is high, according to the latched `we`. The counter decrements each cycle. At count 0:
  - a read captures `mem_rdata` into `rdata`;
  - go to RESP.
- RESP: all memory controls low. Pulse `done[gnt_id]`. Go to IDLE. No grant is made in RESP, so there is always one idle cycle between accesses.
- Arbitration with both requests high: fixed priority to port 0 (see Configuration).
- A requester that drops `req` mid-access does not abort the access; the access completes and `done` still pulses.
- `mem_adr`, `mem_wdata`, and `mem_MW` must not change within an ACCESS window, so the memory sees no glitching write address.

## Timing
- Reset values: state IDLE; `done0`, `done1`, `mem_MR`, `mem_MW`, `busy`, `gnt_id` = 0; `mem_adr`, `mem_wdata`, `rdata` = 0; counter = 0.
- Latency: request high at edge N → ACCESS cycles N+1 … N+MEM_LAT → `done` high in cycle N+MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- `rst` asserted mid-ACCESS: `mem_MW` and `mem_MR` drop immediately (asynchronously). The in-flight write may or may not have landed, and no `done` is issued. The requester re-issues the access after reset.
- `rdata` is unchanged by write accesses.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the port not equal to the last `gnt_id` wins. After reset, port 0 wins the first tie.
- Not defined: fixed priority, port 0 always wins ties. Port 1 can be starved; that is acceptable for the debug loader.

## Structure
- Shared package `dmem_pkg`:
  - state enum `dmem_arb_state_t` {IDLE, ACCESS, RESP};
  - `DMEM_WORDS` = 512;
  - `DMEM_DW` = 32.
- One sub-module: `dmem_rr_pick`. It is combinational: takes `req0`, `req1`, last grant → winner. It is instantiated under both configurations, and the macro selects the tie rule inside it.

## Test plan
- Single read, MEM_LAT=1: port 0 reads 0x0000_0010 with memory word 4 = 0xDEAD_BEEF → `mem_MR` high for 1 cycle with `mem_adr`=0x10, `done0` 2 cycles after request, `rdata`=0xDEAD_BEEF.
- Write then read-back: port 1 writes 0x1234_5678 to 0x0000_0020, then reads it → `mem_MW` high 1 cycle, `done1` pulses, read returns 0x1234_5678, `rdata` unchanged by the write.
- Simultaneous requests:
  - without `DMEM_ARB_RR_EN`, both held high for 4 accesses → `done0` ×4 and `done1` never;
  - with the macro → grants alternate 0, 1, 0, 1.
- MEM_LAT=3, misaligned address 0x0000_0013 → `mem_adr`=0x10, controls stable for 3 cycles, `done` at request+4.
- Reset mid-ACCESS (MEM_LAT=3, `rst` in the 2nd ACCESS cycle) → `mem_MW`=0 immediately, no `done`, `busy`=0, next request is served normally.
- Early `req` drop: port 0 deasserts `req0` during ACCESS → access completes, `done0` pulses once, arbiter returns to IDLE.
